// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU definitions: operand width, opcode width and opcode encodings.
package alu_exec_stage_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned ALU_OP_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_AND = 2'b00,
    ALU_OP_OR  = 2'b01,
    ALU_OP_ADD = 2'b10,
    ALU_OP_SUB = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational 64-bit ALU: AND, OR, ADD, SUB (modulo 2^XLEN, carry discarded).
module alu
  import alu_exec_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [XLEN-1:0]     result_o
);

  always_comb begin
    result_o = '0;
    case (alu_op_e'(op_i))
      ALU_OP_AND: result_o = a_i & b_i;
      ALU_OP_OR:  result_o = a_i | b_i;
      ALU_OP_ADD: result_o = a_i + b_i;
      ALU_OP_SUB: result_o = a_i - b_i;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: registers ALU results behind a main + skid buffer pair so that
// in_ready comes from a flop and never depends combinationally on out_ready.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [XLEN-1:0]     in_arg1,
  input  logic [XLEN-1:0]     in_arg2,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_zero,
  output logic [CNT_W-1:0]    retired_cnt
);

  logic [XLEN-1:0]  alu_res;
  logic             alu_zero;
  logic             in_fire;
  logic             out_fire;

  logic             main_v_q, main_v_d;
  logic [XLEN-1:0]  main_res_q, main_res_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_zero_q, main_zero_d;

  logic             skid_v_q, skid_v_d;
  logic [XLEN-1:0]  skid_res_q, skid_res_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_zero_q, skid_zero_d;

  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  alu u_alu (
    .op_i     (in_op),
    .a_i      (in_arg1),
    .b_i      (in_arg2),
    .result_o (alu_res)
  );

  assign alu_zero = (alu_res == '0);

  // rdy_q resets to 1; masking with rst holds in_ready low only while reset is asserted
  assign in_ready = rdy_q & ~rst;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v_q & out_ready;

  always_comb begin
    main_v_d    = main_v_q;
    main_res_d  = main_res_q;
    main_tag_d  = main_tag_q;
    main_zero_d = main_zero_q;
    skid_v_d    = skid_v_q;
    skid_res_d  = skid_res_q;
    skid_tag_d  = skid_tag_q;
    skid_zero_d = skid_zero_q;
    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, out_fire};

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_fire || !main_v_q) begin
      // in_ready is low whenever skid is occupied, so skid refill and input fire never coincide
      if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_res_d  = skid_res_q;
        main_tag_d  = skid_tag_q;
        main_zero_d = skid_zero_q;
        skid_v_d    = 1'b0;
      end else if (in_fire) begin
        main_v_d    = 1'b1;
        main_res_d  = alu_res;
        main_tag_d  = in_tag;
        main_zero_d = alu_zero;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_v_d    = 1'b1;
      skid_res_d  = alu_res;
      skid_tag_d  = in_tag;
      skid_zero_d = alu_zero;
    end

    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      main_res_q  <= '0;
      main_tag_q  <= '0;
      main_zero_q <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_res_q  <= '0;
      skid_tag_q  <= '0;
      skid_zero_q <= 1'b0;
      rdy_q       <= 1'b1;
      cnt_q       <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_res_q  <= main_res_d;
      main_tag_q  <= main_tag_d;
      main_zero_q <= main_zero_d;
      skid_v_q    <= skid_v_d;
      skid_res_q  <= skid_res_d;
      skid_tag_q  <= skid_tag_d;
      skid_zero_q <= skid_zero_d;
      rdy_q       <= rdy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = main_v_q;
  assign out_result  = main_res_q;
  assign out_tag     = main_tag_q;
  assign out_zero    = main_zero_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a 2-deep FIFO reference model checked every cycle,
// plus directed literal checks; a CNT_W=4 copy shares the stimulus to exercise wrap.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [63:0] in_arg1 = '0;
  logic [63:0] in_arg2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_zero;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic [31:0] retired_cnt;

  logic        in_ready4, out_valid4, out_zero4;
  logic [63:0] out_result4;
  logic [4:0]  out_tag4;
  logic [3:0]  retired_cnt4;

  always #5 clk = ~clk;

  alu_exec_stage #(.TAG_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_arg1(in_arg1), .in_arg2(in_arg2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .retired_cnt(retired_cnt)
  );

  alu_exec_stage #(.TAG_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op),
    .in_arg1(in_arg1), .in_arg2(in_arg2), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_tag(out_tag4), .out_zero(out_zero4), .retired_cnt(retired_cnt4)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          started  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] r;
    logic [4:0]  t;
    logic        z;
  } ent_t;

  function automatic ent_t ref_op(input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [4:0] t);
    ent_t e;
    case (op)
      2'd0:    e.r = a & b;
      2'd1:    e.r = a | b;
      2'd2:    e.r = a + b;
      default: e.r = a - b;
    endcase
    e.t = t;
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  // Reference: the stage behaves as an in-order queue of capacity 2 whose head is shown on out_*
  ent_t        q[$];
  ent_t        shown = '{r: 64'd0, t: 5'd0, z: 1'b0};
  int unsigned m_cnt = 0;

  always @(negedge clk) begin
    bit infire, outfire;
    if (started) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, !rst && q.size() < 2});
      chk("out_result", out_result, shown.r);
      chk("out_tag", {59'd0, out_tag}, {59'd0, shown.t});
      chk("out_zero", {63'd0, out_zero}, {63'd0, shown.z});
      chk("retired_cnt", {32'd0, retired_cnt}, {32'd0, m_cnt});
      chk("w4_out_valid", {63'd0, out_valid4}, {63'd0, q.size() > 0});
      chk("w4_in_ready", {63'd0, in_ready4}, {63'd0, !rst && q.size() < 2});
      chk("w4_out_result", out_result4, shown.r);
      chk("w4_out_tag", {59'd0, out_tag4}, {59'd0, shown.t});
      chk("w4_retired_cnt", {60'd0, retired_cnt4}, 64'(m_cnt % 16));
    end
    if (rst) begin
      q.delete();
      shown = '{r: 64'd0, t: 5'd0, z: 1'b0};
      m_cnt = 0;
    end else begin
      infire  = in_valid && (q.size() < 2);
      outfire = (q.size() > 0) && out_ready;
      if (outfire) m_cnt++;
      if (flush) q.delete();
      else begin
        if (outfire) void'(q.pop_front());
        if (infire) q.push_back(ref_op(in_op, in_arg1, in_arg2, in_tag));
        if (q.size() > 0) shown = q[0];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_arg1  = a;
    in_arg2  = b;
    in_tag   = t;
  endtask

  task automatic send_rand();
    logic [63:0] a, b;
    a = {$urandom(), $urandom()};
    b = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
    send(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)));
  endtask

  initial begin
    step();
    step();
    started = 1'b1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // ADD 5+7 tag 3
    out_ready = 1'b1;
    send(2'd2, 64'd5, 64'd7, 5'd3);
    step();
    in_valid = 1'b0;
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_result", out_result, 64'd12);
    chk("t1_tag", {59'd0, out_tag}, 64'd3);
    chk("t1_zero", {63'd0, out_zero}, 64'd0);
    step();
    chk("t1_cnt", {32'd0, retired_cnt}, 64'd1);

    // SUB 0-1 then SUB 9-9 back to back
    send(2'd3, 64'd0, 64'd1, 5'd4);
    step();
    chk("t2_sub_neg", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_sub_neg_zero", {63'd0, out_zero}, 64'd0);
    send(2'd3, 64'd9, 64'd9, 5'd5);
    step();
    in_valid = 1'b0;
    chk("t2_sub_eq", out_result, 64'd0);
    chk("t2_sub_eq_zero", {63'd0, out_zero}, 64'd1);
    step();

    // backpressure fills main then skid
    out_ready = 1'b0;
    send(2'd0, 64'hF0F0, 64'hFF00, 5'd1);
    step();
    send(2'd1, 64'hF0F0, 64'h0F0F, 5'd2);
    step();
    in_valid = 1'b0;
    chk("t3_ready_low", {63'd0, in_ready}, 64'd0);
    chk("t3_tag_hold", {59'd0, out_tag}, 64'd1);
    chk("t3_and", out_result, 64'hF000);
    step();
    chk("t3_tag_stable", {59'd0, out_tag}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("t3_tag2", {59'd0, out_tag}, 64'd2);
    chk("t3_or", out_result, 64'hFFFF);
    chk("t3_ready_back", {63'd0, in_ready}, 64'd1);
    step();
    chk("t3_drained", {63'd0, out_valid}, 64'd0);
    chk("t3_cnt", {32'd0, retired_cnt}, 64'd5);

    // 100-op stream at full rate
    for (int i = 0; i < 100; i++) begin
      send_rand();
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t4_cnt", {32'd0, retired_cnt}, 64'd105);

    // flush with both entries full
    out_ready = 1'b0;
    send(2'd2, 64'd1, 64'd2, 5'd10);
    step();
    send(2'd2, 64'd3, 64'd4, 5'd11);
    step();
    flush = 1'b1;
    send(2'd2, 64'd5, 64'd6, 5'd12);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_stale_tag", {59'd0, out_tag}, 64'd10);
    // flush with an input fire and an output fire in the same cycle
    send(2'd2, 64'd7, 64'd8, 5'd13);
    step();
    flush = 1'b1;
    out_ready = 1'b1;
    send(2'd2, 64'd9, 64'd10, 5'd14);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_flush_cnt", {32'd0, retired_cnt}, 64'd106);
    step();
    chk("t5_no_ghost", {63'd0, out_valid}, 64'd0);

    // reset with both entries full
    out_ready = 1'b0;
    send(2'd1, 64'd1, 64'd2, 5'd20);
    step();
    send(2'd1, 64'd3, 64'd4, 5'd21);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_result", out_result, 64'd0);
    chk("t6_cnt", {32'd0, retired_cnt}, 64'd0);
    chk("t6_ready_in_rst", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("t6_ready_after", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_rand();
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t6_cnt4_wrap", {60'd0, retired_cnt4}, 64'd0);
    chk("t6_cnt32", {32'd0, retired_cnt}, 64'd16);

    // random traffic with backpressure, flushes and occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) send_rand();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
